phase_timer: RTL and testbench

Parametrised phase timer for the traffic-light controller. It generalises the fixed 50 MHz one-second counter with a configurable prescaler and count width. It adds a loadable terminal value, up/down counting, pause, optional auto-reload, and terminal-count signalling (`done` pulse, sticky `expired`). The controller FSM loads one phase duration per light state and advances when `done` fires.

---
 rtl/phase_timer.sv | 126 ++++++++++++
 tb/tb_phase_timer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//
// Phase timer for the traffic-light controller. A prescaler divides clk by
// CLK_DIV to produce a step; each step moves the count one place towards a
// loadable terminal value (up from 0 to term, or down from term to 0). When
// the terminal value is reached, a one-cycle done pulse fires and a sticky
// expired flag is set. With auto_reload the phase restarts from its start
// value on the step after the terminal value.
//
// Parameters:
//   CLK_DIV      clk cycles per tick (>= 1)
//   CNT_W        width of count and terminal value
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset, clears all state
//   restart      clears prescaler, count back to start value, keeps term
//   load         captures load_val as terminal value and starts a phase
//   load_val     terminal value sampled on load
//   enable       1 = run, 0 = freeze prescaler and count
//   mode         0 = count up to term, 1 = count down to 0
//   auto_reload  restart the phase automatically after the terminal value
//   count        current count
//   tick         one-cycle pulse on each prescaler wrap
//   done         one-cycle pulse when count reaches the terminal value
//   expired      sticky terminal flag
// -----------------------------------------------------------------------------
module phase_timer #(
   parameter int unsigned CLK_DIV = 50000000,
   parameter int unsigned CNT_W   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             enable,
   input  logic             mode,
   input  logic             auto_reload,
   output logic [CNT_W-1:0] count,
   output logic             tick,
   output logic             done,
   output logic             expired
);

   localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

   logic [PRE_W-1:0] r_pre;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_term;
   logic             r_tick;
   logic             r_done;
   logic             r_expired;

   logic             w_step;
   logic             w_at_term;
   logic             w_next_at_term;
   logic             w_fire;
   logic [CNT_W-1:0] w_start;
   logic [CNT_W-1:0] w_next_count;

   always_comb begin
      w_step    = enable && (r_pre == PRE_MAX);
      w_start   = mode ? r_term : '0;
      w_at_term = mode ? (r_count == '0) : (r_count == r_term);

      w_next_count = r_count;
      if (!w_at_term) begin
         w_next_count = mode ? (r_count - CNT_W'(1)) : (r_count + CNT_W'(1));
      end else if (auto_reload) begin
         w_next_count = w_start;
      end

      w_next_at_term = mode ? (w_next_count == '0) : (w_next_count == r_term);
      // A count parked on a non-reloading terminal must not re-fire done;
      // with reload every arrival (including term=0 reloads) counts.
      w_fire = w_next_at_term && (!w_at_term || auto_reload);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pre     <= '0;
         r_count   <= '0;
         r_term    <= '1;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_expired <= 1'b0;
      end else if (restart) begin
         r_pre     <= '0;
         r_count   <= w_start;
         r_tick    <= 1'b0;
         r_done    <= 1'b0;
         r_expired <= 1'b0;
      end else if (load) begin
         r_term    <= load_val;
         r_pre     <= '0;
         r_count   <= mode ? load_val : '0;
         r_tick    <= 1'b0;
         // A zero-length phase is already at its terminal value.
         r_done    <= (load_val == '0);
         r_expired <= (load_val == '0);
      end else if (w_step) begin
         r_pre   <= '0;
         r_tick  <= 1'b1;
         r_count <= w_next_count;
         r_done  <= w_fire;
         if (w_fire) begin
            r_expired <= 1'b1;
         end
      end else begin
         if (enable) begin
            r_pre <= r_pre + PRE_W'(1);
         end
         r_tick <= 1'b0;
         r_done <= 1'b0;
      end
   end

   assign count   = r_count;
   assign tick    = r_tick;
   assign done    = r_done;
   assign expired = r_expired;

endmodule

// File: tb/tb_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_phase_timer
//
// Directed scenarios followed by a randomized run. A behavioural model
// tracks the phase in plain integers and every cycle all outputs are
// compared against it; the directed scenarios also check the hand-derived
// timing points directly.
// -----------------------------------------------------------------------------
module tb_phase_timer;

   localparam int CLK_DIV = 4;
   localparam int CNT_W   = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             restart;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             enable;
   logic             mode;
   logic             auto_reload;
   logic [CNT_W-1:0] count;
   logic             tick;
   logic             done;
   logic             expired;

   int compared   = 0;
   int mismatched = 0;

   // behavioural model state
   int m_phase;   // enabled cycles elapsed in the current prescale period
   int m_cnt;
   int m_term;
   bit m_tick;
   bit m_done;
   bit m_exp;

   phase_timer #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .restart(restart), .load(load),
      .load_val(load_val), .enable(enable), .mode(mode),
      .auto_reload(auto_reload), .count(count), .tick(tick),
      .done(done), .expired(expired)
   );

   always #5 clk = ~clk;

   function automatic bit at_terminal(int c, bit md, int t);
      return md ? (c == 0) : (c == t);
   endfunction

   // One rising edge of the reference phase timer.
   task automatic model_edge();
      bit was_term;
      int start_val;
      start_val = mode ? m_term : 0;
      m_tick = 0;
      m_done = 0;
      if (reset) begin
         m_phase = 0; m_cnt = 0; m_term = (1 << CNT_W) - 1; m_exp = 0;
      end else if (restart) begin
         m_phase = 0; m_cnt = start_val; m_exp = 0;
      end else if (load) begin
         m_term  = int'(load_val);
         m_phase = 0;
         m_cnt   = mode ? m_term : 0;
         m_done  = (m_term == 0);
         m_exp   = (m_term == 0);
      end else if (enable) begin
         m_phase = m_phase + 1;
         if (m_phase == CLK_DIV) begin
            m_phase  = 0;
            m_tick   = 1;
            was_term = at_terminal(m_cnt, mode, m_term);
            if (!was_term)        m_cnt = mode ? m_cnt - 1 : m_cnt + 1;
            else if (auto_reload) m_cnt = start_val;
            m_done = at_terminal(m_cnt, mode, m_term) && (!was_term || auto_reload);
            if (m_done) m_exp = 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock: inputs set at negedge are sampled at posedge, the
   // model steps, outputs are compared 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check("count",   {28'd0, count}, m_cnt);
      check("tick",    {31'd0, tick},  {31'd0, m_tick});
      check("done",    {31'd0, done},  {31'd0, m_done});
      check("expired", {31'd0, expired}, {31'd0, m_exp});
      @(negedge clk);
   endtask

   initial begin
      reset = 1; restart = 0; load = 0; load_val = '0;
      enable = 0; mode = 0; auto_reload = 0;
      m_phase = 0; m_cnt = 0; m_term = 15; m_tick = 0; m_done = 0; m_exp = 0;
      @(negedge clk);
      cyc();
      cyc();
      reset = 0;
      check("rst_count",   {28'd0, count}, 0);
      check("rst_tick",    {31'd0, tick}, 0);
      check("rst_done",    {31'd0, done}, 0);
      check("rst_expired", {31'd0, expired}, 0);

      // up mode, load 3
      enable = 1; load = 1; load_val = 4'd3;
      cyc();
      load = 0;
      repeat (4) cyc();
      check("up_c1", {28'd0, count}, 1);
      repeat (4) cyc();
      check("up_c2", {28'd0, count}, 2);
      repeat (4) cyc();
      check("up_c3", {28'd0, count}, 3);
      check("up_done", {31'd0, done}, 1);
      check("up_exp", {31'd0, expired}, 1);
      for (int i = 1; i <= 12; i++) begin
         cyc();
         check("up_hold_done", {31'd0, done}, 0);
      end
      check("up_hold_cnt", {28'd0, count}, 3);

      // down mode with auto-reload, load 2
      mode = 1; auto_reload = 1; load = 1; load_val = 4'd2;
      cyc();
      load = 0;
      check("dn_c0", {28'd0, count}, 2);
      for (int i = 1; i <= 24; i++) begin
         cyc();
         check("dn_done", {31'd0, done}, {31'd0, (i == 8 || i == 20)});
         if (i == 12) check("dn_reload", {28'd0, count}, 2);
      end

      // pause with pre=2
      mode = 0; auto_reload = 0; load = 1; load_val = 4'd10;
      cyc();
      load = 0;
      cyc();
      cyc();
      enable = 0;
      repeat (5) cyc();
      check("pause_cnt", {28'd0, count}, 0);
      enable = 1;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("pause_tick", {31'd0, tick}, {31'd0, (i == 2)});
      end
      check("pause_c1", {28'd0, count}, 1);

      // restart, load and due step together
      load = 1; load_val = 4'd10;
      cyc();
      load = 0;
      repeat (3) cyc();
      restart = 1; load = 1; load_val = 4'd5;
      cyc();
      restart = 0; load = 0;
      check("prio_cnt", {28'd0, count}, 0);
      check("prio_tick", {31'd0, tick}, 0);
      mode = 1; restart = 1;
      cyc();
      restart = 0;
      check("prio_term", {28'd0, count}, 10);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         check("prio_pre", {31'd0, tick}, {31'd0, (i == 4)});
      end
      check("prio_c9", {28'd0, count}, 9);

      // zero-length phase
      mode = 0; load = 1; load_val = 4'd0;
      cyc();
      load = 0;
      check("zero_done", {31'd0, done}, 1);
      check("zero_exp", {31'd0, expired}, 1);
      for (int i = 1; i <= 12; i++) begin
         cyc();
         check("zero_nodone", {31'd0, done}, 0);
      end

      // reset on a due terminal step
      load = 1; load_val = 4'd1;
      cyc();
      load = 0;
      repeat (3) cyc();
      reset = 1;
      cyc();
      reset = 0;
      check("rstd_cnt", {28'd0, count}, 0);
      check("rstd_tick", {31'd0, tick}, 0);
      check("rstd_done", {31'd0, done}, 0);
      check("rstd_exp", {31'd0, expired}, 0);
      mode = 1; restart = 1;
      cyc();
      restart = 0;
      check("rstd_term", {28'd0, count}, 15);

      // randomized run
      for (int i = 0; i < 1500; i++) begin
         reset       = ($urandom_range(0, 127) == 0);
         restart     = ($urandom_range(0, 47) == 0);
         load        = ($urandom_range(0, 23) == 0);
         load_val    = CNT_W'($urandom_range(0, 15) & ($urandom_range(0, 1) ? 4'h3 : 4'hF));
         enable      = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 31) == 0) mode = ~mode;
         if ($urandom_range(0, 15) == 0) auto_reload = ~auto_reload;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
